// File: rtl/port8080_tgt_pkg.sv
// port8080_pkg: shared types for the 8080-style bus target.
//   state_e  : bus-side FSM states (IDLE, WR_ACT, RD_ACT, ERR)
//   RS_CMD / RS_DATA : register-select encodings (0 = command, 1 = data)
//   ENTRY_W / entry_t : write-stream entry, packed as {rs, data[7:0]}
package port8080_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_ACT,
    ST_RD_ACT,
    ST_ERR
  } state_e;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  localparam int unsigned ENTRY_W = 9;
  typedef logic [ENTRY_W-1:0] entry_t;

  function automatic entry_t mk_entry(input logic rs_bit, input logic [7:0] data);
    return {rs_bit, data};
  endfunction

endpackage

// File: rtl/port8080_tgt_fifo.sv
// port8080_tgt_fifo: circular write buffer for {rs,data} entries.
// Parameters: DEPTH (power of two, >= 2).
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   i_push, i_din : write request and entry
//   i_pop         : read request (head advances)
//   o_dout        : head entry
//   o_full        : DEPTH entries held
//   o_empty       : no entries held
// A push while full is ignored unless a pop happens in the same cycle.
module port8080_tgt_fifo
  import port8080_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_push,
  input  entry_t i_din,
  input  logic   i_pop,
  output entry_t o_dout,
  output logic   o_full,
  output logic   o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic   [AW:0] r_wptr;
  logic   [AW:0] r_rptr;
  entry_t        r_mem [DEPTH];
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_din;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/port8080_tgt.sv
// port8080_tgt: target side of an 8-bit 8080-style parallel bus.
// Host strobes and data are synchronized, decoded into a {rs,data} write
// stream, and host reads are answered from the client's rd_data_i byte.
// Build option: define PORT8080_TGT_FIFO_EN for a FIFO_DEPTH-entry write
// FIFO; otherwise a single holding register buffers writes.
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   cs_n, wr_n, rd_n, rs     : asynchronous host bus controls
//   data_i / data_o, data_oe : host data bus in / out / pad output enable
//   m_data, m_rs, m_valid, m_ready : write stream to internal client
//   rd_data_i, rd_next       : read byte from client, consume pulse
//   ovf, proto_err, err_clr  : sticky error flags and their clear
module port8080_tgt
  import port8080_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       rs,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       data_oe,
  output logic [7:0] m_data,
  output logic       m_rs,
  output logic       m_valid,
  input  logic       m_ready,
  input  logic [7:0] rd_data_i,
  output logic       rd_next,
  output logic       ovf,
  output logic       proto_err,
  input  logic       err_clr
);

  localparam int unsigned BUS_W = 12;  // {cs_n, wr_n, rd_n, rs, data[7:0]}

  logic [BUS_W-1:0] r_sync [SYNC_STAGES];
  logic [BUS_W-1:0] r_edge;
  logic             r_armed;
  state_e           r_state;
  logic [7:0]       r_data_o;
  logic             r_data_oe;
  logic             r_rd_next;
  entry_t           r_wlat;
  logic             r_ovf;
  logic             r_proto_err;

  logic   w_cs_n, w_wr_n, w_rd_n, w_sel, w_wr_lo, w_rd_lo;
  entry_t w_bus_entry;
  logic   w_to_err, w_push, w_rd_done, w_pop, w_full, w_empty;
  entry_t w_dout;

  // Input synchronizer followed by the edge register the FSM decides on.
  // Reset clears the chain to zero so a strobe still low from before reset
  // cannot look like a fresh idle-high bus (see r_armed).
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_edge <= '0;
    end else begin
      r_sync[0] <= {cs_n, wr_n, rd_n, rs, data_i};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_edge <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_cs_n      = r_edge[11];
  assign w_wr_n      = r_edge[10];
  assign w_rd_n      = r_edge[9];
  assign w_sel       = ~w_cs_n;
  assign w_wr_lo     = ~w_wr_n;
  assign w_rd_lo     = ~w_rd_n;
  assign w_bus_entry = mk_entry(r_edge[8], r_edge[7:0]);

  // After reset, transactions start only once both strobes were seen high,
  // so a write or read interrupted by reset is abandoned rather than resumed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_armed <= 1'b0;
    end else if (w_wr_n && w_rd_n) begin
      r_armed <= 1'b1;
    end
  end

  assign w_to_err  = ((r_state == ST_IDLE) && r_armed && w_sel && w_wr_lo && w_rd_lo) ||
                     ((r_state == ST_WR_ACT) && w_sel && w_rd_lo) ||
                     ((r_state == ST_RD_ACT) && w_sel && w_wr_lo);
  assign w_push    = (r_state == ST_WR_ACT) && !w_to_err && (w_wr_n || w_cs_n);
  assign w_rd_done = (r_state == ST_RD_ACT) && !w_to_err && (w_rd_n || w_cs_n);

  // r_wlat keeps refreshing while wr is low, so the pushed entry is the
  // synchronized bus value from the cycle before the strobe went high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_data_o  <= '0;
      r_data_oe <= 1'b0;
      r_rd_next <= 1'b0;
      r_wlat    <= '0;
    end else begin
      r_rd_next <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_to_err) begin
            r_state <= ST_ERR;
          end else if (r_armed && w_sel && w_wr_lo) begin
            r_state <= ST_WR_ACT;
            r_wlat  <= w_bus_entry;
          end else if (r_armed && w_sel && w_rd_lo) begin
            r_state   <= ST_RD_ACT;
            r_data_o  <= rd_data_i;
            r_data_oe <= 1'b1;
          end
        end
        ST_WR_ACT: begin
          if (w_to_err) begin
            r_state <= ST_ERR;
          end else if (w_push) begin
            r_state <= ST_IDLE;
          end else begin
            r_wlat <= w_bus_entry;
          end
        end
        ST_RD_ACT: begin
          if (w_to_err) begin
            r_state   <= ST_ERR;
            r_data_oe <= 1'b0;
          end else if (w_rd_done) begin
            r_state   <= ST_IDLE;
            r_data_oe <= 1'b0;
            r_rd_next <= 1'b1;
          end
        end
        ST_ERR: begin
          r_data_oe <= 1'b0;
          if (w_wr_n && w_rd_n) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_data_oe <= 1'b0;
        end
      endcase
    end
  end

  assign w_pop = m_valid & m_ready;

`ifdef PORT8080_TGT_FIFO_EN
  port8080_tgt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (r_wlat),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
`else
  entry_t r_hold;
  logic   r_hold_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
    end else if (w_push && (!r_hold_valid || w_pop)) begin
      r_hold       <= r_wlat;
      r_hold_valid <= 1'b1;
    end else if (w_pop) begin
      r_hold_valid <= 1'b0;
    end
  end

  assign w_dout  = r_hold;
  assign w_full  = r_hold_valid;
  assign w_empty = ~r_hold_valid;
`endif

  // Sticky flags; a clear wins over a set arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ovf       <= 1'b0;
      r_proto_err <= 1'b0;
    end else if (err_clr) begin
      r_ovf       <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_push && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
      if (w_to_err) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign data_o    = r_data_o;
  assign data_oe   = r_data_oe;
  assign rd_next   = r_rd_next;
  assign m_data    = w_dout[7:0];
  assign m_rs      = w_dout[8];
  assign m_valid   = ~w_empty;
  assign ovf       = r_ovf;
  assign proto_err = r_proto_err;

endmodule
